// File: rtl/rmw_store_unit_pkg.sv
// Shared types and the byte-enable helper for the read-modify-write store unit.
package rmw_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_RESP
    } state_e;

    localparam int MAX_LANES = 8;

    // Enables lanes [offset, offset + 2**size - 1], clipped to the word's lane count.
    function automatic logic [MAX_LANES-1:0] lane_mask(input size_e size, input logic [2:0] offset,
                                                       input int lanes);
        logic [MAX_LANES-1:0] m;
        int width;
        m = '0;
        width = 1 << size;
        for (int k = 0; k < MAX_LANES; k++) begin
            m[k] = (k < lanes) && (k >= int'(offset)) && (k < int'(offset) + width);
        end
        return m;
    endfunction

endpackage

// File: rtl/rmw_store_unit_lane_merge.sv
// Byte-lane merge: each enabled lane takes the new byte, the rest keep the old word.
module lane_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_i,
    input  logic [DATA_W-1:0]   new_i,
    input  logic [DATA_W/8-1:0] mask_i,
    output logic [DATA_W-1:0]   merged_o
);

    for (genvar k = 0; k < DATA_W / 8; k++) begin : g_lane
        assign merged_o[8*k +: 8] = mask_i[k] ? new_i[8*k +: 8] : old_i[8*k +: 8];
    end

endmodule

// File: rtl/rmw_store_unit.sv
// Sub-word store unit: validates a request, then reads, merges and writes back one memory word.
module rmw_store_unit
    import rmw_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [DATA_W-1:0] req_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              resp_valid,
    output logic              resp_err
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    size_e             size_q;
    logic [DATA_W-1:0] data_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic              resp_valid_q;
    logic              resp_err_q;

    logic [OFF_W-1:0]  offset;
    logic [2:0]        align_bits;
    logic              misaligned;
    logic              illegal;
    logic              full_word;
    logic [LANES-1:0]  mask;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] merged;
    logic [ADDR_W-1:0] word_addr;

    assign offset     = addr_q[OFF_W-1:0];
    assign align_bits = 3'((4'd1 << size_q) - 4'd1);
    assign misaligned = |(addr_q[2:0] & align_bits);
    // A size wider than the memory word can never be serviced.
    assign illegal    = (32'd1 << size_q) > 32'(LANES);
    assign full_word  = (32'd1 << size_q) == 32'(LANES);
    assign mask       = LANES'(lane_mask(size_q, 3'(offset), LANES));
    assign shifted    = data_q << {offset, 3'b000};
    assign word_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    lane_merge #(.DATA_W(DATA_W)) u_merge (
        .old_i    (mem_rdata),
        .new_i    (shifted),
        .mask_i   (mask),
        .merged_o (merged)
    );

    // Strobes are registered on entry to the state that owns them, so each lasts one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            size_q       <= SZ_BYTE;
            data_q       <= '0;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            wdata_q      <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        size_q  <= size_e'(req_size);
                        data_q  <= req_data;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (misaligned || illegal) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        state_q      <= ST_RESP;
                    end else if (full_word) begin
                        mem_addr_q <= word_addr;
                        wdata_q    <= data_q;
                        wr_en_q    <= 1'b1;
                        state_q    <= ST_WRITE;
                    end else begin
                        mem_addr_q <= word_addr;
                        rd_en_q    <= 1'b1;
                        state_q    <= ST_READ;
                    end
                end
                ST_READ: begin
                    cnt_q   <= 4'(MEM_LAT);
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q <= 4'd1) begin
                        cnt_q   <= '0;
                        wdata_q <= merged;
                        wr_en_q <= 1'b1;
                        state_q <= ST_WRITE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_WRITE: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign mem_addr   = mem_addr_q;
    assign mem_rd_en  = rd_en_q;
    assign mem_wr_en  = wr_en_q;
    assign mem_wdata  = wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_rmw_store_unit.sv
// Directed bench for rmw_store_unit: a 32-bit/latency-1 instance and a 64-bit/latency-3 instance.
module tb_rmw_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // 32-bit instance
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [31:0] a_addr = '0;
    logic [1:0]  a_size = '0;
    logic [31:0] a_data = '0;
    logic [31:0] a_mem_addr;
    logic        a_rd, a_wr, a_resp, a_err;
    logic [31:0] a_rdata, a_wdata;
    logic [31:0] a_mem_word = '0;
    logic        a_pipe = 1'b0;

    // 64-bit instance
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [31:0] b_addr = '0;
    logic [1:0]  b_size = '0;
    logic [63:0] b_data = '0;
    logic [31:0] b_mem_addr;
    logic        b_rd, b_wr, b_resp, b_err;
    logic [63:0] b_rdata, b_wdata;
    logic [63:0] b_mem_word = '0;
    logic [2:0]  b_pipe = '0;

    rmw_store_unit #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_addr(a_addr),
        .req_size(a_size), .req_data(a_data), .mem_addr(a_mem_addr), .mem_rd_en(a_rd),
        .mem_rdata(a_rdata), .mem_wr_en(a_wr), .mem_wdata(a_wdata), .resp_valid(a_resp),
        .resp_err(a_err)
    );

    rmw_store_unit #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_addr(b_addr),
        .req_size(b_size), .req_data(b_data), .mem_addr(b_mem_addr), .mem_rd_en(b_rd),
        .mem_rdata(b_rdata), .mem_wr_en(b_wr), .mem_wdata(b_wdata), .resp_valid(b_resp),
        .resp_err(b_err)
    );

    // Memory models: read data is valid only in the cycle the unit must capture it.
    always @(posedge clk) begin
        a_pipe <= a_rd;
        b_pipe <= {b_pipe[1:0], b_rd};
    end
    assign a_rdata = a_pipe ? a_mem_word : 32'h0BAD0BAD;
    assign b_rdata = b_pipe[2] ? b_mem_word : 64'h0BAD0BAD0BAD0BAD;

    // Results of the most recent run()
    int          rd_n, wr_n, resp_n, resp_cyc;
    logic [31:0] rd_addr, wr_addr;
    logic [63:0] wdata;
    logic        err;

    task automatic run(input bit w64, input logic [31:0] addr, input logic [1:0] size,
                       input logic [63:0] data, input bit hold);
        int   w;
        logic rd, wr, rv, re;
        logic [31:0] ma;
        logic [63:0] wd;
        @(negedge clk);
        if (w64) begin
            b_valid = 1'b1; b_addr = addr; b_size = size; b_data = data;
        end else begin
            a_valid = 1'b1; a_addr = addr; a_size = size; a_data = data[31:0];
        end
        w = 0;
        while (!(w64 ? b_ready : a_ready) && w < 20) begin
            @(negedge clk);
            w++;
        end
        tests_run++;
        if (w >= 20) begin
            tests_failed++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, required 1", w);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            a_valid = 1'b0;
            b_valid = 1'b0;
        end
        rd_n = 0; wr_n = 0; resp_n = 0; resp_cyc = 0;
        rd_addr = '0; wr_addr = '0; wdata = '0; err = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (w64) begin
                rd = b_rd; wr = b_wr; rv = b_resp; re = b_err; ma = b_mem_addr; wd = b_wdata;
            end else begin
                rd = a_rd; wr = a_wr; rv = a_resp; re = a_err; ma = a_mem_addr; wd = {32'h0, a_wdata};
            end
            if (rd) begin rd_n++; rd_addr = ma; end
            if (wr) begin wr_n++; wr_addr = ma; wdata = wd; end
            if (rv) begin
                resp_n++;
                if (resp_n == 1) begin resp_cyc = c; err = re; end
                a_valid = 1'b0;
                b_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({a_ready, a_rd, a_wr, a_resp, a_err} !== 5'b10000 || a_mem_addr !== 32'h0 || a_wdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_a: rdy/rd/wr/resp/err=%b addr=%h wdata=%h, required 10000 0 0",
                     {a_ready, a_rd, a_wr, a_resp, a_err}, a_mem_addr, a_wdata);
        end
        tests_run++;
        if ({b_ready, b_rd, b_wr, b_resp, b_err} !== 5'b10000 || b_mem_addr !== 32'h0 || b_wdata !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_b: rdy/rd/wr/resp/err=%b addr=%h wdata=%h, required 10000 0 0",
                     {b_ready, b_rd, b_wr, b_resp, b_err}, b_mem_addr, b_wdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        a_mem_word = 32'hAAAAAAAA;
        run(1'b0, 32'h81234561, 2'd0, 64'hFF, 1'b0);
        tests_run++;
        if (rd_n !== 1 || rd_addr !== 32'h81234560) begin
            tests_failed++;
            $display("FAIL basic_read: %0d reads at %h, required 1 at 81234560", rd_n, rd_addr);
        end
        tests_run++;
        if (wr_n !== 1 || wr_addr !== 32'h81234560 || wdata !== 64'hAAAAFFAA) begin
            tests_failed++;
            $display("FAIL basic_write: %0d writes of %h at %h, required 1 of aaaaffaa at 81234560",
                     wr_n, wdata, wr_addr);
        end
        tests_run++;
        if (resp_n !== 1 || resp_cyc !== 5 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_resp: %0d resp at cycle %0d err=%b, required 1 at 5 err=0",
                     resp_n, resp_cyc, err);
        end
    endtask

    task automatic test_byte_sweep();
        logic [31:0] exp_tab [4];
        exp_tab = '{32'hAAAAAAFF, 32'hAAAAFFAA, 32'hAAFFAAAA, 32'hFFAAAAAA};
        a_mem_word = 32'hAAAAAAAA;
        for (int i = 0; i < 4; i++) begin
            run(1'b0, 32'h81234560 + 32'(i), 2'd0, 64'hFF, 1'b0);
            tests_run++;
            if (wr_n !== 1 || wdata !== {32'h0, exp_tab[i]} || resp_cyc !== 5) begin
                tests_failed++;
                $display("FAIL byte_sweep_%0d: %0d writes of %h resp at %0d, required 1 of %h at 5",
                         i, wr_n, wdata, resp_cyc, exp_tab[i]);
            end
        end
    endtask

    task automatic test_half();
        a_mem_word = 32'hAAAAAAAA;
        run(1'b0, 32'h81234562, 2'd1, 64'h1234, 1'b0);
        tests_run++;
        if (wr_n !== 1 || wdata !== 64'h1234AAAA || resp_cyc !== 5 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL half: %0d writes of %h resp at %0d err=%b, required 1 of 1234aaaa at 5 err=0",
                     wr_n, wdata, resp_cyc, err);
        end
    endtask

    task automatic test_errors();
        run(1'b0, 32'h81234563, 2'd1, 64'h1234, 1'b0);
        tests_run++;
        if (rd_n !== 0 || wr_n !== 0 || resp_n !== 1 || resp_cyc !== 2 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL misaligned_half: rd=%0d wr=%0d resp=%0d at %0d err=%b, required 0 0 1 at 2 err=1",
                     rd_n, wr_n, resp_n, resp_cyc, err);
        end
        run(1'b0, 32'h81234560, 2'd3, 64'h1122334455667788, 1'b0);
        tests_run++;
        if (rd_n !== 0 || wr_n !== 0 || resp_n !== 1 || resp_cyc !== 2 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL dword_on_32: rd=%0d wr=%0d resp=%0d at %0d err=%b, required 0 0 1 at 2 err=1",
                     rd_n, wr_n, resp_n, resp_cyc, err);
        end
        run(1'b1, 32'h8123450A, 2'd2, 64'h12345678, 1'b0);
        tests_run++;
        if (rd_n !== 0 || wr_n !== 0 || resp_cyc !== 2 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL misaligned_word_64: rd=%0d wr=%0d resp at %0d err=%b, required 0 0 at 2 err=1",
                     rd_n, wr_n, resp_cyc, err);
        end
    endtask

    task automatic test_word();
        run(1'b0, 32'h81234564, 2'd2, 64'hDEADBEEF, 1'b0);
        tests_run++;
        if (rd_n !== 0 || wr_n !== 1 || wr_addr !== 32'h81234564 || wdata !== 64'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL word_write: rd=%0d wr=%0d of %h at %h, required 0 1 of deadbeef at 81234564",
                     rd_n, wr_n, wdata, wr_addr);
        end
        tests_run++;
        if (resp_n !== 1 || resp_cyc !== 3 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL word_resp: %0d resp at %0d err=%b, required 1 at 3 err=0", resp_n, resp_cyc, err);
        end
    endtask

    task automatic test_wide();
        b_mem_word = 64'h1111111111111111;
        run(1'b1, 32'h8123450D, 2'd0, 64'h5A, 1'b0);
        tests_run++;
        if (rd_n !== 1 || rd_addr !== 32'h81234508 || wr_n !== 1 || wdata !== 64'h11115A1111111111) begin
            tests_failed++;
            $display("FAIL wide_byte: rd=%0d at %h wr=%0d of %h, required 1 at 81234508 1 of 11115a1111111111",
                     rd_n, rd_addr, wr_n, wdata);
        end
        tests_run++;
        if (resp_cyc !== 7 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL wide_latency: resp at %0d err=%b, required 7 err=0", resp_cyc, err);
        end
        run(1'b1, 32'h8123450E, 2'd1, 64'hBEEF, 1'b0);
        tests_run++;
        if (wr_n !== 1 || wdata !== 64'hBEEF111111111111 || resp_cyc !== 7) begin
            tests_failed++;
            $display("FAIL wide_half: %0d writes of %h resp at %0d, required 1 of beef111111111111 at 7",
                     wr_n, wdata, resp_cyc);
        end
        run(1'b1, 32'h8123450C, 2'd2, 64'hCAFEF00D, 1'b0);
        tests_run++;
        if (wr_n !== 1 || wdata !== 64'hCAFEF00D11111111 || resp_cyc !== 7) begin
            tests_failed++;
            $display("FAIL wide_word: %0d writes of %h resp at %0d, required 1 of cafef00d11111111 at 7",
                     wr_n, wdata, resp_cyc);
        end
        run(1'b1, 32'h81234508, 2'd3, 64'h0123456789ABCDEF, 1'b0);
        tests_run++;
        if (rd_n !== 0 || wr_n !== 1 || wdata !== 64'h0123456789ABCDEF || resp_cyc !== 3) begin
            tests_failed++;
            $display("FAIL wide_dword: rd=%0d wr=%0d of %h resp at %0d, required 0 1 of 0123456789abcdef at 3",
                     rd_n, wr_n, wdata, resp_cyc);
        end
    endtask

    task automatic test_reset_in_wait();
        int w;
        int bad;
        b_mem_word = 64'h2222222222222222;
        @(negedge clk);
        b_valid = 1'b1; b_addr = 32'h81234508; b_size = 2'd0; b_data = 64'h77;
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        w = 0;
        while (!b_rd && w < 10) begin
            @(negedge clk);
            w++;
        end
        tests_run++;
        if (w >= 10) begin
            tests_failed++;
            $display("FAIL rst_wait_read: no mem_rd_en within %0d cycles, required one", w);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({b_ready, b_rd, b_wr, b_resp} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL rst_wait_state: rdy/rd/wr/resp=%b, required 1000", {b_ready, b_rd, b_wr, b_resp});
        end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (b_wr || b_resp) bad++;
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("FAIL rst_wait_dropped: %0d cycles with write or resp after reset, required 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        a_mem_word = 32'hAAAAAAAA;
        run(1'b0, 32'h81234563, 2'd0, 64'h3C, 1'b1);
        tests_run++;
        if (wr_n !== 1 || resp_n !== 1 || wdata !== 64'h3CAAAAAA) begin
            tests_failed++;
            $display("FAIL held_valid: %0d writes of %h, %0d resps, required 1 of 3caaaaaa, 1 resp",
                     wr_n, wdata, resp_n);
        end
        run(1'b0, 32'h81234560, 2'd1, 64'h5566, 1'b0);
        tests_run++;
        if (wr_n !== 1 || resp_n !== 1 || wdata !== 64'hAAAA5566 || resp_cyc !== 5) begin
            tests_failed++;
            $display("FAIL back_to_back: %0d writes of %h, %0d resps at %0d, required 1 of aaaa5566, 1 at 5",
                     wr_n, wdata, resp_n, resp_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_byte_sweep();
        test_half();
        test_errors();
        test_word();
        test_wide();
        test_reset_in_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rmw_store_unit.md
Name: rmw_store_unit

Overview:
- Sequential, parametrised successor to the combinational byte-insert word modifier.
- Accepts sub-word store requests (byte/half/word/dword) and performs a read-modify-write against a word-wide memory port with a configurable read latency.
- Full-width aligned stores skip the read.
- Sits between the datapath store stage and the data memory; single request in flight.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, memory word width in bits; power of two, 16..64.
- MEM_LAT, 1, cycles from mem_rd_en to valid mem_rdata; 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  store request valid.
- req_ready  out  1  unit idle and able to accept a request.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  0=byte, 1=half, 2=word, 3=dword (3 legal only if DATA_W=64).
- req_data  in  DATA_W  store data, right-justified (LSBs used).
- mem_addr  out  ADDR_W  word-aligned address (low log2(DATA_W/8) bits zero).
- mem_rd_en  out  1  one-cycle read strobe.
- mem_rdata  in  DATA_W  read data, sampled exactly MEM_LAT cycles after mem_rd_en.
- mem_wr_en  out  1  one-cycle write strobe.
- mem_wdata  out  DATA_W  merged word.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  qualifies resp_valid: misaligned or illegal size; no memory access made.

Behaviour:
- Reset values: req_ready=1; mem_rd_en, mem_wr_en, resp_valid, resp_err=0; mem_addr, mem_wdata=0; state IDLE; latency counter 0.
- Acceptance: a transfer occurs when req_valid && req_ready. Address, size and data are registered. req_ready=1 only in IDLE.
- Lane numbering is little-endian: byte lane k = mem word bits [8k+7:8k], k = addr low bits.
- Alignment: the request is misaligned if addr mod (1<<size) != 0. Size 3 with DATA_W=32 is illegal.
- FSM states: IDLE, CHECK, READ, WAIT, WRITE, RESP.
  - IDLE -> CHECK on accept.
  - CHECK, on error: -> RESP with resp_err=1.
  - CHECK, if size covers the full word: -> WRITE; mem_wdata = req_data.
  - CHECK, otherwise: -> READ.
  - READ: mem_rd_en=1 for one cycle, mem_addr driven; load counter = MEM_LAT; -> WAIT.
  - WAIT: decrement counter; when it reaches 0, capture mem_rdata and merge. The merged word replaces lanes [k, k+(1<<size)-1] with the low bytes of req_data; other lanes are unchanged. -> WRITE.
  - WRITE: mem_wr_en=1 for one cycle with mem_addr and mem_wdata. -> RESP.
  - RESP: resp_valid=1 for one cycle, resp_err as determined. -> IDLE. req_ready returns 1 on the following cycle.
- Latency, accept to resp_valid:
  - Sub-word: 4+MEM_LAT cycles.
  - Full-word: 3 cycles.
  - Error: 2 cycles.
- mem_addr holds its value from READ through WRITE. mem_wdata is held after WRITE until the next write.
- req_valid while busy is ignored (req_ready=0); the requester must hold the request.
- rst asserted in any state: next edge goes to IDLE with all strobes 0. A write not yet issued is dropped; no resp_valid.
- The address upper bits pass through unchanged; no wrap handling is needed since word alignment only clears low bits.
- mem_rdata is ignored outside the capture cycle.

Decomposition:
- Package rmw_pkg:
  - size_e enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD).
  - state_e enum.
  - lane_mask function (size, offset, lanes) returning a byte-enable vector.
- Sub-module lane_merge (combinational):
  - Inputs: old word, new data, byte mask.
  - Output: merged word.
  - Generalises the existing byte-insert block to all sizes and widths.

Test Plan:
- DATA_W=32, MEM_LAT=1; addr 0x81234561, size 0, data 0xFF; mem returns 0xAAAAAAAA -> one read at 0x81234560, one write of 0xAAAAFFAA, resp_valid after 5 cycles, resp_err=0.
- Sweep addr 0x...60–0x...63, byte 0xFF over 0xAAAAAAAA -> writes 0xAAAAAAFF, 0xAAAAFFAA, 0xAAFFAAAA, 0xFFAAAAAA.
- Halfword 0x1234 at 0x...62 over 0xAAAAAAAA -> 0x1234AAAA. Halfword at 0x...63 -> resp_err=1 after 2 cycles, no mem_rd_en or mem_wr_en.
- Word 0xDEADBEEF at 0x...64 -> no mem_rd_en, write 0xDEADBEEF, resp after 3 cycles.
- DATA_W=64, MEM_LAT=3; byte 0x5A at 0x...0D over 0x1111111111111111 -> 0x11115A1111111111, resp after 7 cycles. Size 3 with DATA_W=32 -> resp_err.
- rst asserted during WAIT -> no mem_wr_en, no resp_valid, req_ready=1 next cycle. req_valid held during busy -> exactly one transaction per accept.
